// File: rtl/stopwatch_tick_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_tick_ctrl_if
// Brief    : Button inputs and tick/control outputs of the stopwatch tick
//            controller. The master modport drives the buttons and the slave
//            modport (the controller) drives the outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_tick_ctrl_if #(
    parameter int CNT_W = 26
);
    logic             btn_start_n;
    logic             btn_clear_n;
    logic             tick_en;
    logic             clear_pulse;
    logic             running;
    logic [CNT_W-1:0] prescale_q;
    logic             done;

    modport master (
        output btn_start_n,
        output btn_clear_n,
        input  tick_en,
        input  clear_pulse,
        input  running,
        input  prescale_q,
        input  done
    );

    modport slave (
        input  btn_start_n,
        input  btn_clear_n,
        output tick_en,
        output clear_pulse,
        output running,
        output prescale_q,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_tick_ctrl
// Brief    : Run/pause/clear controlled tick source for the seconds counter.
//            Synchronises and debounces the start and clear buttons, runs an
//            IDLE/RUN/PAUSE state machine and emits tick_en once every
//            TICK_DIV cycles while running.
//            Optional macro TICK_LIMIT_EN adds a tick counter and a DONE
//            state entered after MAX_TICKS ticks.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_tick_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int CNT_W      = 26,
    parameter int DEB_CYCLES = 1000000,
    parameter int MAX_TICKS  = 99
) (
    input  wire                  clk,
    input  wire                  reset,
    stopwatch_tick_ctrl_if.slave bus
);

    localparam int               c_DEB_W     = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
`ifdef TICK_LIMIT_EN
    localparam int                 c_TCNT_W   = $clog2(MAX_TICKS + 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(MAX_TICKS - 1);
`endif

`ifdef TICK_LIMIT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;
`endif

    // Bit 0 = start button, bit 1 = clear button
    logic [1:0]       w_raw;
    logic [1:0]       w_press;
    logic             w_start_press;
    logic             w_clear_press;
    logic             w_tick_en;

    state_t           r_state;
    logic [CNT_W-1:0] r_prescale;
`ifdef TICK_LIMIT_EN
    logic [c_TCNT_W-1:0] r_tick_cnt;
`endif

    assign w_raw = {bus.btn_clear_n, bus.btn_start_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]         r_sync;
            logic               r_deb;
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_press;

            // Two-flop synchroniser followed by a stable-level debouncer;
            // a press strobe fires only on an accepted high-to-low change
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync  <= 2'b11;
                    r_deb   <= 1'b1;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    if (r_sync[1] == r_deb) begin
                        r_cnt   <= '0;
                        r_press <= 1'b0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_deb   <= r_sync[1];
                        r_cnt   <= '0;
                        r_press <= ~r_sync[1];
                    end else begin
                        r_cnt   <= r_cnt + c_DEB_W'(1);
                        r_press <= 1'b0;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    assign w_start_press = w_press[0];
    assign w_clear_press = w_press[1];

    // A clear in the terminal cycle suppresses that cycle's tick
    assign w_tick_en = (r_state == S_RUN) && (r_prescale == c_TICK_LAST) &&
                       !w_clear_press;

    // Control state machine and prescaler; clear overrides every other event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prescale <= '0;
`ifdef TICK_LIMIT_EN
            r_tick_cnt <= '0;
`endif
        end else if (w_clear_press) begin
            r_state    <= S_IDLE;
            r_prescale <= '0;
`ifdef TICK_LIMIT_EN
            r_tick_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prescale <= '0;
                    if (w_start_press) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_prescale == c_TICK_LAST) begin
                        r_prescale <= '0;
                    end else begin
                        r_prescale <= r_prescale + CNT_W'(1);
                    end
                    if (w_start_press) begin
                        r_state <= S_PAUSE;
                    end
`ifdef TICK_LIMIT_EN
                    // Reaching the limit takes precedence over a pause
                    if (w_tick_en) begin
                        r_tick_cnt <= r_tick_cnt + c_TCNT_W'(1);
                        if (r_tick_cnt == c_TCNT_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
`endif
                end
                S_PAUSE: begin
                    if (w_start_press) begin
                        r_state <= S_RUN;
                    end
                end
`ifdef TICK_LIMIT_EN
                S_DONE: begin
                    r_prescale <= '0;
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_prescale <= '0;
                end
            endcase
        end
    end

    assign bus.tick_en     = w_tick_en;
    assign bus.clear_pulse = w_clear_press;
    assign bus.running     = (r_state == S_RUN);
    assign bus.prescale_q  = r_prescale;
`ifdef TICK_LIMIT_EN
    assign bus.done        = (r_state == S_DONE);
`else
    assign bus.done        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_tick_ctrl
// Brief    : Directed self-checking bench for stopwatch_tick_ctrl with
//            TICK_DIV=10, DEB_CYCLES=4, MAX_TICKS=3. Covers the
//            TICK_LIMIT_EN build when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_tick_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int CNT_W      = 4;
    localparam int DEB_CYCLES = 4;
    localparam int MAX_TICKS  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ps      = 0;
    int ticks       = 0;

    always #5 clk = ~clk;

    stopwatch_tick_ctrl_if #(.CNT_W(CNT_W)) sw_if ();

    stopwatch_tick_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W),
        .DEB_CYCLES(DEB_CYCLES),
        .MAX_TICKS (MAX_TICKS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sw_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Continuous RUN: prescaler counts modulo TICK_DIV, tick only at the top
    task automatic run_check(input int n);
        repeat (n) begin
            step(1);
            exp_ps = (exp_ps + 1) % TICK_DIV;
            chk("run_ps", 32'(sw_if.prescale_q), 32'(exp_ps));
            chk("run_tick", 32'(sw_if.tick_en), 32'(exp_ps == TICK_DIV - 1));
            chk("run_running", 32'(sw_if.running), 32'd1);
            chk("run_clear", 32'(sw_if.clear_pulse), 32'd0);
            chk("run_done", 32'(sw_if.done), 32'd0);
            if (sw_if.tick_en === 1'b1) ticks++;
        end
    endtask

    // Not running (IDLE or PAUSE): prescaler frozen at ps, no tick, no clear
    task automatic hold_check(input int n, input int ps);
        repeat (n) begin
            step(1);
            chk("hold_ps", 32'(sw_if.prescale_q), 32'(ps));
            chk("hold_tick", 32'(sw_if.tick_en), 32'd0);
            chk("hold_running", 32'(sw_if.running), 32'd0);
            chk("hold_clear", 32'(sw_if.clear_pulse), 32'd0);
            chk("hold_done", 32'(sw_if.done), 32'd0);
        end
    endtask

    initial begin
        sw_if.btn_start_n = 1'b1;
        sw_if.btn_clear_n = 1'b1;
        reset = 1'b1;
        #23;
        chk("rst_tick", 32'(sw_if.tick_en), 32'd0);
        chk("rst_clear", 32'(sw_if.clear_pulse), 32'd0);
        chk("rst_running", 32'(sw_if.running), 32'd0);
        chk("rst_done", 32'(sw_if.done), 32'd0);
        chk("rst_ps", 32'(sw_if.prescale_q), 32'd0);
        reset = 1'b0;
        step(1);

        // 50 idle cycles
        hold_check(50, 0);

        // Start press: strobe after 6 edges, RUN on the 7th
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 0);
        step(1);
        chk("start_running", 32'(sw_if.running), 32'd1);
        chk("start_ps", 32'(sw_if.prescale_q), 32'd0);
        exp_ps = 0;
        ticks  = 0;
        run_check(13);
        sw_if.btn_start_n = 1'b1;
        run_check(17);
        chk("run_tick_count", 32'(ticks), 32'd3);

        // Pause landing with the prescaler held at 6
        run_check(9);
        sw_if.btn_start_n = 1'b0;
        run_check(6);
        step(1);
        chk("pause_running", 32'(sw_if.running), 32'd0);
        chk("pause_ps", 32'(sw_if.prescale_q), 32'd6);
        chk("pause_tick", 32'(sw_if.tick_en), 32'd0);
        hold_check(3, 6);
        sw_if.btn_start_n = 1'b1;
        hold_check(27, 6);
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 6);
        step(1);
        chk("resume_running", 32'(sw_if.running), 32'd1);
        chk("resume_ps", 32'(sw_if.prescale_q), 32'd6);
        chk("resume_tick", 32'(sw_if.tick_en), 32'd0);
        exp_ps = 6;
        ticks  = 0;
        run_check(3);
        chk("resume_tick_after3", 32'(ticks), 32'd1);
        sw_if.btn_start_n = 1'b1;

        // 3-cycle glitch must be ignored: RUN continues uninterrupted
        run_check(7);
        sw_if.btn_start_n = 1'b0;
        run_check(3);
        sw_if.btn_start_n = 1'b1;
        run_check(10);

        // Start and clear together while running: clear wins
        sw_if.btn_start_n = 1'b0;
        sw_if.btn_clear_n = 1'b0;
        run_check(5);
        step(1);
        chk("both_clear_pulse", 32'(sw_if.clear_pulse), 32'd1);
        chk("both_tick", 32'(sw_if.tick_en), 32'd0);
        chk("both_ps", 32'(sw_if.prescale_q), 32'd5);
        step(1);
        chk("both_clear_end", 32'(sw_if.clear_pulse), 32'd0);
        chk("both_running", 32'(sw_if.running), 32'd0);
        chk("both_ps_zero", 32'(sw_if.prescale_q), 32'd0);
        hold_check(3, 0);
        sw_if.btn_start_n = 1'b1;
        sw_if.btn_clear_n = 1'b1;
        hold_check(7, 0);

        // Start press strobe coinciding with prescale_q == TICK_DIV-1
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 0);
        step(1);
        chk("start2_running", 32'(sw_if.running), 32'd1);
        exp_ps = 0;
        run_check(3);
        sw_if.btn_start_n = 1'b1;
        run_check(10);
        sw_if.btn_start_n = 1'b0;
        run_check(6);
        chk("edge_tick", 32'(sw_if.tick_en), 32'd1);
        step(1);
        chk("edge_pause_running", 32'(sw_if.running), 32'd0);
        chk("edge_pause_ps", 32'(sw_if.prescale_q), 32'd0);
        chk("edge_pause_tick", 32'(sw_if.tick_en), 32'd0);
        hold_check(3, 0);
        sw_if.btn_start_n = 1'b1;
        hold_check(10, 0);

        // Resume, then asynchronous reset at prescale_q == 5
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 0);
        step(1);
        chk("start3_running", 32'(sw_if.running), 32'd1);
        exp_ps = 0;
        run_check(3);
        sw_if.btn_start_n = 1'b1;
        run_check(2);
        chk("pre_reset_ps", 32'(sw_if.prescale_q), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ps", 32'(sw_if.prescale_q), 32'd0);
        chk("async_rst_running", 32'(sw_if.running), 32'd0);
        chk("async_rst_tick", 32'(sw_if.tick_en), 32'd0);
        chk("async_rst_clear", 32'(sw_if.clear_pulse), 32'd0);
        chk("async_rst_done", 32'(sw_if.done), 32'd0);
        step(2);
        reset = 1'b0;
        hold_check(5, 0);

`ifdef TICK_LIMIT_EN
        // Tick limit: DONE after the 3rd tick, start ignored, clear exits
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 0);
        step(1);
        chk("lim_running", 32'(sw_if.running), 32'd1);
        exp_ps = 0;
        ticks  = 0;
        run_check(3);
        sw_if.btn_start_n = 1'b1;
        run_check(26);
        chk("lim_ticks", 32'(ticks), 32'd3);
        step(1);
        chk("lim_done", 32'(sw_if.done), 32'd1);
        chk("lim_running_off", 32'(sw_if.running), 32'd0);
        chk("lim_ps", 32'(sw_if.prescale_q), 32'd0);
        sw_if.btn_start_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("done_hold_done", 32'(sw_if.done), 32'd1);
            chk("done_hold_running", 32'(sw_if.running), 32'd0);
            chk("done_hold_ps", 32'(sw_if.prescale_q), 32'd0);
            chk("done_hold_tick", 32'(sw_if.tick_en), 32'd0);
        end
        sw_if.btn_start_n = 1'b1;
        sw_if.btn_clear_n = 1'b0;
        step(6);
        chk("done_clear_pulse", 32'(sw_if.clear_pulse), 32'd1);
        step(1);
        chk("done_cleared", 32'(sw_if.done), 32'd0);
        chk("done_cleared_running", 32'(sw_if.running), 32'd0);
        chk("done_cleared_pulse", 32'(sw_if.clear_pulse), 32'd0);
        sw_if.btn_clear_n = 1'b1;
        hold_check(8, 0);
`else
        // No limit: run well past MAX_TICKS, done stays low throughout
        sw_if.btn_start_n = 1'b0;
        hold_check(6, 0);
        step(1);
        chk("free_running", 32'(sw_if.running), 32'd1);
        exp_ps = 0;
        ticks  = 0;
        run_check(3);
        sw_if.btn_start_n = 1'b1;
        run_check(60);
        chk("free_ticks_gt5", 32'(ticks > 5), 32'd1);
        // Clear landing on the terminal count suppresses the tick
        sw_if.btn_clear_n = 1'b0;
        run_check(5);
        step(1);
        chk("clr_top_ps", 32'(sw_if.prescale_q), 32'd9);
        chk("clr_top_tick", 32'(sw_if.tick_en), 32'd0);
        chk("clr_top_pulse", 32'(sw_if.clear_pulse), 32'd1);
        step(1);
        chk("clr_top_running", 32'(sw_if.running), 32'd0);
        chk("clr_top_ps_zero", 32'(sw_if.prescale_q), 32'd0);
        sw_if.btn_clear_n = 1'b1;
        hold_check(8, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_tick_ctrl.md
Name: stopwatch_tick_ctrl

Overview:
- Upstream control stage for the two-digit seconds counter.
- Replaces the free-running prescaler with a run/pause/clear controlled tick source.
- Debounces two push buttons, runs a start/pause/clear state machine, and emits a one-cycle tick_en every TICK_DIV clock cycles while running.
- tick_en drives the seconds counter enable; clear_pulse is the downstream counter clear.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick_en pulse (1 s at 50 MHz); legal range >= 2.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.
- DEB_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept a button level change; legal range >= 2.
- MAX_TICKS, 99, tick limit; used only with TICK_LIMIT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_start_n  input  1  raw start/pause push button, active-low, asynchronous to clk
- btn_clear_n  input  1  raw clear push button, active-low, asynchronous to clk
- tick_en  output  1  one-cycle pulse, one per elapsed TICK_DIV while running
- clear_pulse  output  1  one-cycle pulse on accepted clear
- running  output  1  high in RUN state
- prescale_q  output  CNT_W  current prescaler value
- done  output  1  tick limit reached (TICK_LIMIT_EN only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, prescale_q=0, tick_en=0, clear_pulse=0, running=0, done=0.
  - Synchronizers are set to 1 (released).
  - Debounced levels are set to 1; debounce counters are set to 0.
- Synchronizer:
  - Each button passes through a 2-flop synchronizer.
  - No logic may use the raw inputs directly.
- Debounce, per button:
  - When the synchronized level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - On the cycle the counter equals DEB_CYCLES-1 and the levels still differ, the debounced level takes the synchronized level and the counter clears.
  - A 1->0 change of the debounced level produces a one-cycle press strobe (start_press / clear_press), registered in that cycle.
  - Releases produce no strobe.
  - Any glitch shorter than DEB_CYCLES cycles is ignored.
- FSM states: IDLE, RUN, PAUSE, plus DONE with TICK_LIMIT_EN.
  - IDLE: prescaler held at 0; start_press -> RUN.
  - RUN: prescaler increments each cycle.
    - At prescale_q == TICK_DIV-1: tick_en=1 for that cycle, and prescaler wraps to 0 on the next edge.
    - start_press -> PAUSE.
  - PAUSE: prescaler holds its value; start_press -> RUN, resuming from the held value (no tick lost or added).
  - clear_press in any state -> IDLE on the next edge.
    - prescaler -> 0 on the same edge.
    - clear_pulse=1 for exactly one cycle, coincident with the clear_press strobe.
- tick_en is combinational from the registered state and prescaler (RUN && prescale_q==TICK_DIV-1).
  - It is never high outside RUN.
  - It is high for exactly 1 cycle per period.
  - Period in continuous RUN is exactly TICK_DIV cycles.
- running = (state==RUN).
- Simultaneous events:
  - clear_press with start_press: clear wins; the state goes to IDLE.
  - clear_press while prescale_q==TICK_DIV-1 in RUN: tick_en is suppressed (forced 0) that cycle.
  - start_press while prescale_q==TICK_DIV-1 in RUN: tick_en=1 that cycle, prescaler wraps to 0, state -> PAUSE.
- Reset mid-operation forces all reset values immediately, independent of clk.
- Press latency from raw falling edge to strobe: 2 synchronizer cycles + DEB_CYCLES cycles, ±1 cycle for sampling phase.

Optional Feature:
- TICK_LIMIT_EN defined:
  - An internal tick counter, width ceil(log2(MAX_TICKS+1)), increments on each issued tick_en.
  - On the tick that makes the count equal MAX_TICKS, state -> DONE; done=1 and the prescaler is held at 0.
  - DONE ignores start_press; only clear_press (-> IDLE, tick count 0, done=0) or reset leaves it.
  - clear_press from any state zeroes the tick count.
- TICK_LIMIT_EN undefined:
  - No tick counter and no DONE state; done is tied 0.
  - The block runs indefinitely; the downstream counters wrap on their own.

Test Plan (bench parameters TICK_DIV=10, DEB_CYCLES=4, MAX_TICKS=3):
- Reset then 50 idle cycles -> tick_en, clear_pulse, running, done all 0; prescale_q=0 throughout.
- btn_start_n low for 20 cycles -> one start strobe; running=1 about 6 cycles after the edge; tick_en pulses every 10 cycles, exactly 1 cycle wide, at prescale_q=9.
- Press start in RUN at prescale_q=6, hold PAUSE 30 cycles, press again -> prescale_q stays 6 during pause; the next tick_en arrives 3 cycles after RUN resumes.
- btn_start_n glitch low for 3 cycles -> no strobe; state unchanged. Start and clear pressed the same cycle while running -> clear_pulse=1 one cycle, IDLE, prescale_q=0, no tick.
- Start press timed to land at prescale_q=9 -> tick_en=1 that cycle, then PAUSE with prescale_q=0. Assert reset mid-RUN at prescale_q=5 -> all outputs 0 immediately, asynchronously.
- With TICK_LIMIT_EN: run continuously -> done=1 after the 3rd tick_en; start presses ignored; clear -> done=0, IDLE. Without the macro: more than 5 ticks issued, done stays 0.
